// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC and drives a variable-latency req/ack
// instruction memory. Optional perf counters are enabled by FETCH_PERF_CNT_EN.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc_out,
   output logic [31:0] pc_inc,
   output logic [31:0] instruction,
   output logic        bubble
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_wait
`endif
);

   typedef enum logic [1:0] {
      ST_REQ     = 2'd0,
      ST_HOLD    = 2'd1,
      ST_DISCARD = 2'd2
   } state_t;

   state_t      state_q;
   logic [31:0] pc_q;
   logic [31:0] hold_instr_q;
   logic [31:0] req_addr_q;

   logic [31:0] pc_plus4_d;
   logic [31:0] redirect_tgt_d;

   assign pc_plus4_d     = pc_q + 32'd4;
   assign redirect_tgt_d = redirect_pc & 32'hFFFF_FFFC;
   assign pc_out         = pc_q;

   // Presentation is combinational so a zero-wait memory sustains one
   // instruction per cycle; bubble cycles always present zeros.
   always_comb begin
      imem_req    = 1'b0;
      imem_addr   = pc_q;
      instruction = 32'd0;
      pc_inc      = 32'd0;
      bubble      = 1'b1;
      if (!Reset) begin
         case (state_q)
            ST_REQ: begin
               imem_req = 1'b1;
               if (imem_ack && !redirect) begin
                  instruction = imem_rdata;
                  pc_inc      = pc_plus4_d;
                  bubble      = 1'b0;
               end
            end
            ST_HOLD: begin
               if (!redirect) begin
                  instruction = hold_instr_q;
                  pc_inc      = pc_plus4_d;
                  bubble      = 1'b0;
               end
            end
            ST_DISCARD: begin
               imem_req  = 1'b1;
               imem_addr = req_addr_q;
            end
            default: begin
               imem_req = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         pc_q         <= RESET_PC;
         state_q      <= ST_REQ;
         hold_instr_q <= 32'd0;
         req_addr_q   <= 32'd0;
      end else if (redirect) begin
         pc_q <= redirect_tgt_d;
         // An unanswered request must still be drained before refetching.
         if (state_q == ST_REQ && !imem_ack) begin
            req_addr_q <= pc_q;
            state_q    <= ST_DISCARD;
         end else if (state_q != ST_DISCARD) begin
            state_q <= ST_REQ;
         end
      end else begin
         case (state_q)
            ST_REQ: begin
               if (imem_ack) begin
                  if (stall) begin
                     hold_instr_q <= imem_rdata;
                     state_q      <= ST_HOLD;
                  end else begin
                     pc_q <= pc_plus4_d;
                  end
               end
            end
            ST_HOLD: begin
               if (!stall) begin
                  pc_q    <= pc_plus4_d;
                  state_q <= ST_REQ;
               end
            end
            ST_DISCARD: begin
               if (imem_ack) begin
                  state_q <= ST_REQ;
               end
            end
            default: begin
               state_q <= ST_REQ;
            end
         endcase
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic fetched_inc_d;
   logic wait_inc_d;

   assign fetched_inc_d = !bubble && !stall && !redirect;
   assign wait_inc_d    = (state_q == ST_REQ && !imem_ack) || (state_q == ST_DISCARD);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         perf_fetched <= 32'd0;
         perf_wait    <= 32'd0;
      end else begin
         if (fetched_inc_d) perf_fetched <= perf_fetched + 32'd1;
         if (wait_inc_d)    perf_wait    <= perf_wait + 32'd1;
      end
   end
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Owns the PC and drives a variable-latency instruction-memory req/ack interface.
- Presents pc_inc, instruction and bubble to the IF/ID register, which consumes them on the next Clk edge.
- Honours the hazard-unit stall and redirects from branch/jump resolution.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded by Reset; bits [1:0] must be 0.

Ports:
Clk  input  1  clock, all state updates on posedge.
Reset  input  1  synchronous, active-high reset.
stall  input  1  hazard unit: IF/ID holds; do not advance PC.
redirect  input  1  branch/jump taken; squash current fetch.
redirect_pc  input  32  redirect target; bits [1:0] ignored (treated as 0).
imem_req  output  1  fetch request valid.
imem_addr  output  32  fetch address; stable while imem_req=1 and imem_ack=0.
imem_ack  input  1  memory returns imem_rdata this cycle; may be high in the request cycle.
imem_rdata  input  32  instruction word, valid when imem_ack=1.
pc_out  output  32  PC of the instruction being requested or presented.
pc_inc  output  32  pc_out+4 for the presented instruction, to IF/ID.
instruction  output  32  fetched word, to IF/ID.
bubble  output  1  1 = no valid instruction this cycle; IF/ID loads zeros.

Behaviour:
- State: pc (32), hold_instr (32), req_addr (32), and a 3-state FSM: REQ, HOLD, DISCARD.
- Reset cycle: pc<=RESET_PC, FSM<=REQ, hold_instr<=0. While Reset=1: imem_req=0, bubble=1, instruction=0, pc_inc=0. A request outstanding at Reset is abandoned; the memory tolerates a dropped req.
- REQ:
  - imem_req=1, imem_addr=pc.
  - On imem_ack: instruction=imem_rdata, pc_inc=pc+4, bubble=0, combinationally in the same cycle.
  - Without ack: bubble=1, instruction=0, pc_inc=0.
  - ack & !stall & !redirect: pc<=pc+4; stay REQ. Zero-wait memory therefore gives one instruction per cycle.
  - ack & stall & !redirect: hold_instr<=imem_rdata; go HOLD; pc unchanged.
  - !ack & !redirect: stay REQ; address held.
- HOLD:
  - imem_req=0, instruction=hold_instr, pc_inc=pc+4, bubble=0.
  - stall=1: remain.
  - stall=0: pc<=pc+4; go REQ.
- DISCARD:
  - imem_req=1, imem_addr=req_addr (the abandoned address), bubble=1; returned data is dropped.
  - On imem_ack: go REQ at the current pc.
- Redirect (any state) has priority over stall and ack:
  - pc<={redirect_pc[31:2],2'b00}; bubble=1 in that cycle.
  - In REQ with no ack that cycle: req_addr<=pc; go DISCARD.
  - Otherwise: go REQ.
  - A redirect arriving while in DISCARD updates pc only; the state stays DISCARD.
- Arithmetic: pc+4 is modulo 2^32, so 0xFFFF_FFFC wraps to 0x0000_0000.
- pc_out = pc in every state. It is driven even during Reset and shows the old value in the reset cycle.
- stall without a presented instruction (REQ waiting) has no effect on fetching. The IF/ID register ignores bubble while stalled.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: adds outputs perf_fetched (32) and perf_wait (32), both cleared by Reset and wrapping modulo 2^32.
  - perf_fetched increments on cycles with bubble=0 & stall=0 & redirect=0.
  - perf_wait increments on cycles in REQ with imem_ack=0, or in DISCARD.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset, ack tied 1, rdata=addr^32'hA5A5_0000 -> imem_addr 0x0,0x4,0x8 on consecutive cycles; pc_inc 0x4,0x8,0xC; bubble=0 every cycle after Reset.
- Memory latency 2 (ack one cycle after req) -> bubble pattern 1,0,1,0; each address held stable until its ack.
- ack at 0x8 with stall=1 for 3 cycles -> HOLD; imem_req=0; instruction=rdata(0x8) and pc_inc=0xC stable 3 cycles; then next request to 0xC.
- Request to 0x10 pending (latency 3), redirect with redirect_pc=0x40 -> imem_addr stays 0x10 until ack, bubble=1 throughout, word at 0x10 never shows bubble=0; then request 0x40 delivered with pc_inc=0x44.
- Redirect and stall in the same cycle with redirect_pc=0x103 -> next request 0x100; stall ignored for that cycle.
- RESET_PC=0xFFFF_FFFC -> first pc_inc=0x0 and second request to 0x0. Reset asserted mid-HOLD -> bubble=1 next cycle and request restarts at RESET_PC.
